fxp_mac_seq: RTL and testbench

Sequencer for the fixed-point multiply-accumulate path. It accepts a programmed number of signed operand pairs over a valid/ready stream and multiplies each pair at full precision. It accumulates the products in a guarded accumulator. It then resizes the sum to the user output format with optional overflow/underflow saturation and presents one registered result with per-result flags. It sits between the sample source and the result consumer and owns all control of the shared multiplier/accumulator/resize datapath.

---
 rtl/fxp_mac_pkg.sv | 23 ++
 rtl/fxp_acc_resize.sv | 73 +++++++
 rtl/fxp_mac_seq.sv | 139 +++++++++++++
 tb/tb_fxp_mac_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fxp_mac_pkg.sv
// Shared types and default widths for the fixed-point MAC sequencer.
// The derived widths below correspond to the default operand and result formats.
package fxp_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_RESIZE = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    localparam int DEF_WI      = 5;
    localparam int DEF_WF      = 11;
    localparam int DEF_WIO     = 6;
    localparam int DEF_WFO     = 11;
    localparam int DEF_MAX_LEN = 16;

    localparam int PROD_W   = 2 * (DEF_WI + DEF_WF);
    localparam int ACC_W    = PROD_W + $clog2(DEF_MAX_LEN);
    localparam int ACC_FRAC = 2 * DEF_WF;
    localparam int OUT_W    = DEF_WIO + DEF_WFO;

endpackage

// File: rtl/fxp_acc_resize.sv
// Combinational conversion of the guarded accumulator into the result format,
// with overflow/underflow detection and independent integer/fraction saturation.
module fxp_acc_resize #(
    parameter int WI    = 5,
    parameter int WF    = 11,
    parameter int WIO   = 6,
    parameter int WFO   = 11,
    parameter int GUARD = 4
) (
    input  logic [2*(WI+WF)+GUARD-1:0] acc_i,
    input  logic                       of_sat_en_i,
    input  logic                       uf_sat_en_i,
    output logic [WIO+WFO-1:0]         data_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int AW = 2 * (WI + WF) + GUARD;
    localparam int AF = 2 * WF;
    localparam int AI = AW - AF;

    logic           sign;
    logic [WIO-1:0] int_trunc;
    logic [WFO-1:0] frac_trunc;
    logic           ovf;
    logic           unf;
    logic [WIO-1:0] int_f;
    logic [WFO-1:0] frac_f;

    assign sign = acc_i[AW-1];

    generate
        if (WIO < AI) begin : g_int_narrow
            // The result fits only if every bit from the result sign upwards equals the sign.
            logic [AI-WIO:0] top;
            assign top       = acc_i[AW-1 : AF+WIO-1];
            assign ovf       = !((&top) || !(|top));
            assign int_trunc = {sign, acc_i[AF+WIO-2 : AF]};
        end else begin : g_int_wide
            assign ovf       = 1'b0;
            assign int_trunc = WIO'($signed(acc_i[AW-1 : AF]));
        end

        if (AF > WFO) begin : g_frac_narrow
            assign frac_trunc = acc_i[AF-1 -: WFO];
            assign unf        = |acc_i[AF-WFO-1 : 0];
        end else if (AF == WFO) begin : g_frac_equal
            assign frac_trunc = acc_i[AF-1 : 0];
            assign unf        = 1'b0;
        end else begin : g_frac_wide
            assign frac_trunc = {acc_i[AF-1 : 0], {(WFO-AF){1'b0}}};
            assign unf        = 1'b0;
        end
    endgenerate

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        int_f  = int_trunc;
        frac_f = frac_trunc;
        if (ovf && of_sat_en_i) begin
            int_f  = sign ? {1'b1, {(WIO-1){1'b0}}} : {1'b0, {(WIO-1){1'b1}}};
            frac_f = sign ? '0 : '1;
        end
        if (unf && uf_sat_en_i) begin
            frac_f = '1;
        end
    end

    assign data_o      = {int_f, frac_f};
    assign overflow_o  = ovf;
    assign underflow_o = unf;

endmodule

// File: rtl/fxp_mac_seq.sv
// Job sequencer for the shared multiply/accumulate/resize datapath: accepts len
// operand pairs, accumulates their products and presents one registered result.
module fxp_mac_seq
    import fxp_mac_pkg::*;
#(
    parameter int WI      = DEF_WI,
    parameter int WF      = DEF_WF,
    parameter int WIO     = DEF_WIO,
    parameter int WFO     = DEF_WFO,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int GUARD   = $clog2(MAX_LEN)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [LEN_W-1:0]            len,
    input  logic                        of_sat_en,
    input  logic                        uf_sat_en,
    input  logic signed [WI+WF-1:0]     a_data,
    input  logic signed [WI+WF-1:0]     b_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [WIO+WFO-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_overflow,
    output logic                        out_underflow,
    output logic                        busy
);

    localparam int PW = 2 * (WI + WF);
    localparam int AW = PW + GUARD;
    localparam int OW = WIO + WFO;

    state_t                state_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;
    logic                  of_sat_q;
    logic                  uf_sat_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  acc_d;
    logic signed [PW-1:0]  prod;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [OW-1:0]         out_data_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  busy_q;
    logic                  last_pair;
    logic [OW-1:0]         res_data;
    logic                  res_ovf;
    logic                  res_unf;

    assign prod      = a_data * b_data;
    assign acc_d     = acc_q + AW'(prod);
    assign last_pair = (cnt_q == len_q - LEN_W'(1));

    fxp_acc_resize #(
        .WI    (WI),
        .WF    (WF),
        .WIO   (WIO),
        .WFO   (WFO),
        .GUARD (GUARD)
    ) u_resize (
        .acc_i       (acc_q),
        .of_sat_en_i (of_sat_q),
        .uf_sat_en_i (uf_sat_q),
        .data_o      (res_data),
        .overflow_o  (res_ovf),
        .underflow_o (res_unf)
    );

    // NOTE: sequential state uses <= only; the accumulator is a plain register and is reset with the rest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            of_sat_q    <= 1'b0;
            uf_sat_q    <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        len_q      <= len;
                        of_sat_q   <= of_sat_en;
                        uf_sat_q   <= uf_sat_en;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid && in_ready_q) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (last_pair) begin
                            in_ready_q <= 1'b0;
                            state_q    <= ST_RESIZE;
                        end
                    end
                end
                ST_RESIZE: begin
                    out_data_q  <= res_data;
                    ovf_q       <= res_ovf;
                    unf_q       <= res_unf;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fxp_mac_seq.sv
// Directed bench for fxp_mac_seq: hand-computed Q5.11 x Q5.11 -> Q6.11 jobs,
// latency, backpressure, ignored starts and mid-job reset.
module tb_fxp_mac_seq;

    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             of_sat_en = 1'b0;
    logic             uf_sat_en = 1'b0;
    logic [15:0]      a_data = '0;
    logic [15:0]      b_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [16:0]      out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_overflow;
    logic             out_underflow;
    logic             busy;

    int total = 0;
    int bad   = 0;

    fxp_mac_seq dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .len           (len),
        .of_sat_en     (of_sat_en),
        .uf_sat_en     (uf_sat_en),
        .a_data        (a_data),
        .b_data        (b_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive and sample 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string tag, input int n, input logic ofs, input logic ufs,
                           input logic [15:0] a, input logic [15:0] b, input int gap,
                           input int hold, input logic [16:0] exp_d,
                           input logic exp_o, input logic exp_u);
        start     = 1'b1;
        len       = LEN_W'(n);
        of_sat_en = ofs;
        uf_sat_en = ufs;
        tick();
        start = 1'b0;
        check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "/busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            a_data   = a;
            b_data   = b;
            tick();
            in_valid = 1'b0;
            if (i < n - 1) repeat (gap) tick();
        end
        // One edge after the final accept the block is resizing; the next edge shows the result.
        check({tag, "/lat1"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "/lat2"}, 32'(out_valid), 32'd1);
        check({tag, "/data"}, 32'(out_data), 32'(exp_d));
        check({tag, "/ovf"}, 32'(out_overflow), 32'(exp_o));
        check({tag, "/unf"}, 32'(out_underflow), 32'(exp_u));
        check({tag, "/in_ready_out"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                start = 1'b1;
                len   = LEN_W'(1);
            end
            tick();
            start = 1'b0;
            check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "/hold_data"}, 32'(out_data), 32'(exp_d));
            check({tag, "/hold_flags"}, {30'd0, out_overflow, out_underflow}, {30'd0, exp_o, exp_u});
            check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "/drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, "/idle_busy"}, 32'(busy), 32'd0);
        if (hold > 0) begin
            tick();
            check({tag, "/start_ignored"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #1;
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/in_ready", 32'(in_ready), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/out_data", 32'(out_data), 32'd0);
        check("rst/flags", {30'd0, out_overflow, out_underflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 4 x (1.0 * 1.0) = 4.0
        run_job("unit4", 4, 1'b0, 1'b0, 16'h0800, 16'h0800, 0, 0, 17'h02000, 1'b0, 1'b0);
        // 4 x (15.0 * 15.0) = 900 -> saturates to max positive
        run_job("ovf_pos", 4, 1'b1, 1'b0, 16'h7800, 16'h7800, 0, 0, 17'h0FFFF, 1'b1, 1'b0);
        // 4 x (-15.0 * 15.0) = -900 -> saturates to min negative
        run_job("ovf_neg", 4, 1'b1, 1'b0, 16'h8800, 16'h7800, 0, 0, 17'h10000, 1'b1, 1'b0);

        // Reset after two of four pairs: everything returns to zero without a clock edge.
        start = 1'b1;
        len   = LEN_W'(4);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a_data   = 16'h0800;
            b_data   = 16'h0800;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst/out_valid", 32'(out_valid), 32'd0);
        check("midrst/in_ready", 32'(in_ready), 32'd0);
        check("midrst/busy", 32'(busy), 32'd0);
        check("midrst/out_data", 32'(out_data), 32'd0);
        check("midrst/flags", {30'd0, out_overflow, out_underflow}, 32'd0);
        #2;
        reset = 1'b1;
        tick();
        // 2.0 * 0.5 = 1.0
        run_job("post_rst", 1, 1'b0, 1'b0, 16'h1000, 16'h0400, 0, 0, 17'h00800, 1'b0, 1'b0);

        // 900 without saturation keeps sign + low 5 integer bits: 900 mod 32 = 4
        run_job("ovf_wrap", 4, 1'b0, 1'b0, 16'h7800, 16'h7800, 0, 0, 17'h02000, 1'b1, 1'b0);
        // Smallest product 2^-22 is below the output LSB
        run_job("unf_sat", 1, 1'b0, 1'b1, 16'h0001, 16'h0001, 0, 0, 17'h007FF, 1'b0, 1'b1);
        run_job("unf_trunc", 1, 1'b0, 1'b0, 16'h0001, 16'h0001, 0, 0, 17'h00000, 1'b0, 1'b1);
        // Backpressure for 5 cycles with a start pulse that must be ignored; 2 x 1.0 = 2.0
        run_job("bp", 2, 1'b0, 1'b0, 16'h1000, 16'h0400, 0, 5, 17'h01000, 1'b0, 1'b0);
        // in_valid one cycle in three: 3 x 1.0 = 3.0
        run_job("gapped", 3, 1'b0, 1'b0, 16'h1000, 16'h0400, 2, 0, 17'h01800, 1'b0, 1'b0);

        // start with len == 0 is ignored
        start = 1'b1;
        len   = '0;
        tick();
        start = 1'b0;
        check("len0/busy", 32'(busy), 32'd0);
        check("len0/in_ready", 32'(in_ready), 32'd0);
        tick();
        check("len0/busy_later", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
